// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC source encodings and default PC vectors.
package cpu_pkg;

  typedef enum logic [2:0] {
    SelSeq    = 3'd0,
    SelBranch = 3'd1,
    SelJump   = 3'd2,
    SelJr     = 3'd3,
    SelEret   = 3'd4
  } sel_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0040_0004;

  // Encodings 5-7 alias to SEQ, so only 1..4 redirect the PC.
  function automatic logic is_redirect(input logic [2:0] sel);
    logic r;
    r = 1'b0;
    case (sel)
      SelBranch, SelJump, SelJr, SelEret: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target generation for the PC unit.
module npc_calc
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [2:0]       sel,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jidx,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] target,
  output logic             misalign
);

  logic [WIDTH-1:0] br_off;

  assign npc      = pc + WIDTH'(STEP);
  // Word offset, sign-extended and scaled to bytes.
  assign br_off   = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign misalign = (sel == SelJr) && (rs_val[1:0] != 2'b00);

  always_comb begin
    target = npc;
    case (sel)
      SelBranch: target = npc + br_off;
      SelJump:   target = {npc[WIDTH-1:28], jidx, 2'b00};
      SelJr:     target = rs_val;
      SelEret:   target = epc;
      default:   target = npc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with exception PC and a one-entry redirect buffer that holds
// redirects requested while the multi-cycle control unit stalls the PC.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
  parameter int unsigned STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_we,
  input  logic [2:0]       sel,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jidx,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] epc,
  output logic             pend,
  output logic             misalign
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] target;

  npc_calc #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_npc_calc (
    .pc       (pc_q),
    .sel      (sel),
    .imm16    (imm16),
    .jidx     (jidx),
    .rs_val   (rs_val),
    .epc      (epc_q),
    .npc      (npc),
    .target   (target),
    .misalign (misalign)
  );

  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    buf_d  = buf_q;
    pend_d = pend_q;
    if (pc_we) begin
      if (exc_req || misalign) begin
        pc_d   = WIDTH'(EXC_VEC);
        epc_d  = pc_q;
        pend_d = 1'b0;
      end else if (pend_q) begin
        pc_d   = buf_q;
        pend_d = 1'b0;
      end else begin
        pc_d = target;
      end
    end else if (is_redirect(sel) && !misalign) begin
      // Newest stalled redirect overwrites any earlier one.
      buf_d  = target;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= WIDTH'(RESET_VEC);
      epc_q  <= '0;
      buf_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      buf_q  <= buf_d;
      pend_q <= pend_d;
    end
  end

  assign pc   = pc_q;
  assign epc  = epc_q;
  assign pend = pend_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a reference model pushes expected state into a
// scoreboard as each cycle is driven; results are popped after the edge.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst, pc_we, exc_req;
  logic [2:0]  sel;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] rs_val, pc, npc, epc;
  logic        pend, misalign;

  always #5 clk = ~clk;

  pc_unit #(
    .WIDTH     (32),
    .RESET_VEC (RV),
    .EXC_VEC   (EV),
    .STEP      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_we    (pc_we),
    .sel      (sel),
    .imm16    (imm16),
    .jidx     (jidx),
    .rs_val   (rs_val),
    .exc_req  (exc_req),
    .pc       (pc),
    .npc      (npc),
    .epc      (epc),
    .pend     (pend),
    .misalign (misalign)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pend;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc, m_epc, m_buf;
  logic        m_pend;

  function automatic logic [31:0] model_target(input logic [2:0] s, input logic [15:0] im,
                                               input logic [25:0] j, input logic [31:0] rs);
    logic [31:0] np;
    np = m_pc + 32'd4;
    case (s)
      3'd1:    return np + {{14{im[15]}}, im, 2'b00};
      3'd2:    return {np[31:28], j, 2'b00};
      3'd3:    return rs;
      3'd4:    return m_epc;
      default: return np;
    endcase
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the model, then compare after the rising edge.
  task automatic cycle(input string tag, input logic r, input logic we, input logic [2:0] s,
                       input logic [15:0] im, input logic [25:0] j, input logic [31:0] rs,
                       input logic ex);
    exp_t        e;
    logic [31:0] tgt;
    logic        mis;
    rst = r; pc_we = we; sel = s; imm16 = im; jidx = j; rs_val = rs; exc_req = ex;
    #1;
    mis = (s == 3'd3) && (rs[1:0] != 2'b00);
    chk1({tag, ":misalign"}, misalign, mis);
    tgt = model_target(s, im, j, rs);
    if (r) begin
      m_pc = RV; m_epc = '0; m_pend = 1'b0;
    end else if (we) begin
      if (ex || mis) begin
        m_epc = m_pc; m_pc = EV; m_pend = 1'b0;
      end else if (m_pend) begin
        m_pc = m_buf; m_pend = 1'b0;
      end else begin
        m_pc = tgt;
      end
    end else if (s >= 3'd1 && s <= 3'd4 && !mis) begin
      m_buf = tgt; m_pend = 1'b1;
    end
    sb.push_back('{pc: m_pc, epc: m_epc, pend: m_pend});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk32({tag, ":pc"}, pc, e.pc);
    chk32({tag, ":epc"}, epc, e.epc);
    chk1({tag, ":pend"}, pend, e.pend);
    chk32({tag, ":npc"}, npc, e.pc + 32'd4);
  endtask

  initial begin
    cycle("rst0", 1'b1, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    cycle("rst1", 1'b1, 1'b1, 3'd2, 16'h0, 26'h0, 32'h0, 1'b1);
    chk32("reset_pc", pc, 32'h0040_0000);
    chk32("reset_epc", epc, 32'h0);
    chk1("reset_pend", pend, 1'b0);

    cycle("seq1", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("seq1_const", pc, 32'h0040_0004);
    cycle("seq2", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("seq2_const", pc, 32'h0040_0008);
    cycle("seq3", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("seq3_const", pc, 32'h0040_000C);
    cycle("seq4", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);

    cycle("br_neg", 1'b0, 1'b1, 3'd1, 16'hFFFF, 26'h0, 32'h0, 1'b0);
    chk32("br_neg_const", pc, 32'h0040_0010);
    cycle("br_pos", 1'b0, 1'b1, 3'd1, 16'h0003, 26'h0, 32'h0, 1'b0);
    chk32("br_pos_const", pc, 32'h0040_0020);

    cycle("stall_j", 1'b0, 1'b0, 3'd2, 16'h0, 26'h0100040, 32'h0, 1'b0);
    chk1("stall_j_pend", pend, 1'b1);
    chk32("stall_j_hold", pc, 32'h0040_0020);
    cycle("drain_j", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("drain_j_const", pc, 32'h0040_0100);
    chk1("drain_j_pend", pend, 1'b0);

    // Newest wins; stalled exc, misaligned JR and sel=5 must not disturb the buffer.
    cycle("stall_br", 1'b0, 1'b0, 3'd1, 16'h0001, 26'h0, 32'h0, 1'b0);
    cycle("stall_jr", 1'b0, 1'b0, 3'd3, 16'h0, 26'h0, 32'h0040_0200, 1'b0);
    cycle("stall_exc", 1'b0, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b1);
    cycle("stall_mis", 1'b0, 1'b0, 3'd3, 16'h0, 26'h0, 32'h0040_0301, 1'b0);
    cycle("stall_s5", 1'b0, 1'b0, 3'd5, 16'h0, 26'h0, 32'h0, 1'b0);
    cycle("drain_new", 1'b0, 1'b1, 3'd1, 16'h0007, 26'h0, 32'h0, 1'b0);
    chk32("drain_new_const", pc, 32'h0040_0200);

    cycle("jr30", 1'b0, 1'b1, 3'd3, 16'h0, 26'h0, 32'h0040_0030, 1'b0);
    cycle("exc", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b1);
    chk32("exc_pc_const", pc, EV);
    chk32("exc_epc_const", epc, 32'h0040_0030);
    cycle("eret", 1'b0, 1'b1, 3'd4, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("eret_const", pc, 32'h0040_0030);

    cycle("seq34", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    cycle("jr_mis", 1'b0, 1'b1, 3'd3, 16'h0, 26'h0, 32'h0040_0102, 1'b0);
    chk32("jr_mis_pc_const", pc, EV);
    chk32("jr_mis_epc_const", epc, 32'h0040_0034);

    cycle("stall_j2", 1'b0, 1'b0, 3'd2, 16'h0, 26'h0000010, 32'h0, 1'b0);
    cycle("exc_clr", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b1);
    chk1("exc_clr_pend", pend, 1'b0);
    cycle("after_clr", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("after_clr_const", pc, 32'h0040_0008);
    cycle("sel6", 1'b0, 1'b1, 3'd6, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("sel6_const", pc, 32'h0040_000C);

    cycle("jr_top", 1'b0, 1'b1, 3'd3, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
    chk32("wrap_npc", npc, 32'h0000_0000);
    cycle("wrap", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("wrap_const", pc, 32'h0000_0000);

    cycle("stall_j3", 1'b0, 1'b0, 3'd2, 16'h0, 26'h0000123, 32'h0, 1'b0);
    chk1("stall_j3_pend", pend, 1'b1);
    cycle("rst_pend", 1'b1, 1'b1, 3'd3, 16'h0, 26'h0, 32'h0040_0102, 1'b1);
    chk32("rst_pend_pc", pc, RV);
    chk1("rst_pend_pend", pend, 1'b0);
    cycle("post_rst", 1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
    chk32("post_rst_const", pc, 32'h0040_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
